// File: rtl/pcie_link_monitor.sv
// pcie_link_monitor: synchronizes and debounces PCIe link-up, drives a heartbeat LED, and counts qualified link drops
module pcie_link_monitor #(
  parameter int HB_HALF_PERIOD = 62500000,
  parameter int LNK_FILTER_CYCLES = 1024
) (
  input  logic        user_clk,
  input  logic        user_reset,
  input  logic        lnk_up_raw,
  input  logic        drop_count_clr,
  output logic        user_clk_heartbeat,
  output logic        user_lnk_up,
  output logic [1:0]  lnk_state,
  output logic        lnk_drop_pulse,
  output logic [15:0] drop_count
);
  localparam int HW = $clog2(HB_HALF_PERIOD);
  localparam int FW = $clog2(LNK_FILTER_CYCLES);
  typedef enum logic [1:0] {DOWN, TRAINING, UP, LOST} state_t;
  state_t state_q, state_d;
  logic sync_q, lnk_s_q, hb_q, pulse_q, drop, flt_done, hb_wrap;
  logic [HW-1:0] hb_cnt_q;
  logic [FW-1:0] flt_q, flt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  always_comb begin
    flt_done = flt_q == FW'(LNK_FILTER_CYCLES - 1);
    hb_wrap = hb_cnt_q == HW'(HB_HALF_PERIOD - 1);
    state_d = state_q;
    case (state_q)
      DOWN:     state_d = lnk_s_q ? TRAINING : DOWN;
      TRAINING: state_d = !lnk_s_q ? DOWN : flt_done ? UP : TRAINING;
      UP:       state_d = lnk_s_q ? UP : LOST;
      LOST:     state_d = lnk_s_q ? UP : flt_done ? DOWN : LOST;
      default:  state_d = DOWN;
    endcase
    drop = state_q == LOST && !lnk_s_q && flt_done;
    flt_d = state_d != state_q ? '0 : (state_q == TRAINING || state_q == LOST) ? flt_q + 1'b1 : flt_q;
    drop_cnt_d = drop_count_clr ? {15'd0, drop} :
                 (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      sync_q     <= 1'b0;
      lnk_s_q    <= 1'b0;
      state_q    <= DOWN;
      flt_q      <= '0;
      hb_cnt_q   <= '0;
      hb_q       <= 1'b0;
      pulse_q    <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      sync_q     <= lnk_up_raw;
      lnk_s_q    <= sync_q;
      state_q    <= state_d;
      flt_q      <= flt_d;
      hb_cnt_q   <= hb_wrap ? '0 : hb_cnt_q + 1'b1;
      hb_q       <= hb_wrap ? ~hb_q : hb_q;
      pulse_q    <= drop;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign user_clk_heartbeat = hb_q;
  assign user_lnk_up = state_q == UP || state_q == LOST;
  assign lnk_state = state_q;
  assign lnk_drop_pulse = pulse_q;
  assign drop_count = drop_cnt_q;
endmodule

// File: tb/tb_pcie_link_monitor.sv
// tb_pcie_link_monitor: directed checks of sync latency, filtering, heartbeat, drop counting and reset
module tb_pcie_link_monitor;
  logic clk = 1'b0, rst = 1'b1, raw = 1'b0, clr = 1'b0;
  logic hb, lnk_up, pulse;
  logic [1:0] st;
  logic [15:0] dc;
  int vectors = 0, miscompares = 0;
  pcie_link_monitor #(.HB_HALF_PERIOD(5), .LNK_FILTER_CYCLES(4)) dut (
    .user_clk(clk), .user_reset(rst), .lnk_up_raw(raw), .drop_count_clr(clr),
    .user_clk_heartbeat(hb), .user_lnk_up(lnk_up), .lnk_state(st),
    .lnk_drop_pulse(pulse), .drop_count(dc)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [1:0] e_st, input logic e_up, input logic e_p, input logic [15:0] e_dc);
    chk({tag, ".state"}, 32'(st), 32'(e_st));
    chk({tag, ".lnk_up"}, 32'(lnk_up), 32'(e_up));
    chk({tag, ".pulse"}, 32'(pulse), 32'(e_p));
    chk({tag, ".drop_count"}, 32'(dc), 32'(e_dc));
  endtask
  initial begin
    step(2);
    chk_all("reset", 2'd0, 1'b0, 1'b0, 16'd0);
    chk("reset.hb", 32'(hb), 32'd0);
    rst = 1'b0;
    step(4); chk("hb.r4", 32'(hb), 32'd0);
    step(1); chk("hb.r5", 32'(hb), 32'd1);
    step(4); chk("hb.r9", 32'(hb), 32'd1);
    step(1); chk("hb.r10", 32'(hb), 32'd0);
    chk_all("idle", 2'd0, 1'b0, 1'b0, 16'd0);
    raw = 1'b1;
    step(2); chk("up.k2", 32'(st), 32'd0);
    step(1); chk("up.k3", 32'(st), 32'd1);
    step(3); chk_all("up.k6", 2'd1, 1'b0, 1'b0, 16'd0);
    step(1); chk_all("up.k7", 2'd2, 1'b1, 1'b0, 16'd0);
    raw = 1'b0;
    step(2); chk("glitch.k2", 32'(st), 32'd2);
    raw = 1'b1;
    step(1); chk_all("glitch.k3", 2'd3, 1'b1, 1'b0, 16'd0);
    step(1); chk_all("glitch.k4", 2'd3, 1'b1, 1'b0, 16'd0);
    step(1); chk_all("glitch.k5", 2'd2, 1'b1, 1'b0, 16'd0);
    raw = 1'b0;
    step(3); chk("loss.k3", 32'(st), 32'd3);
    step(3); chk_all("loss.k6", 2'd3, 1'b1, 1'b0, 16'd0);
    step(1); chk_all("loss.k7", 2'd0, 1'b0, 1'b1, 16'd1);
    step(1); chk_all("loss.k8", 2'd0, 1'b0, 1'b0, 16'd1);
    raw = 1'b1;
    step(3); chk_all("abort.k3", 2'd1, 1'b0, 1'b0, 16'd1);
    raw = 1'b0;
    step(2); chk_all("abort.k5", 2'd1, 1'b0, 1'b0, 16'd1);
    step(1); chk_all("abort.k6", 2'd0, 1'b0, 1'b0, 16'd1);
    step(3); chk_all("abort.k9", 2'd0, 1'b0, 1'b0, 16'd1);
    force dut.drop_cnt_q = 16'hFFFF;
    step(1);
    release dut.drop_cnt_q;
    step(1); chk("sat.preload", 32'(dc), 32'hFFFF);
    raw = 1'b1;
    step(7); chk("sat.up", 32'(st), 32'd2);
    raw = 1'b0;
    step(7); chk_all("sat.loss", 2'd0, 1'b0, 1'b1, 16'hFFFF);
    raw = 1'b1;
    step(7); chk("clrloss.up", 32'(st), 32'd2);
    raw = 1'b0;
    step(6); chk_all("clrloss.k6", 2'd3, 1'b1, 1'b0, 16'hFFFF);
    clr = 1'b1;
    step(1); chk_all("clrloss.k7", 2'd0, 1'b0, 1'b1, 16'd1);
    clr = 1'b0;
    step(1); chk("clrloss.hold", 32'(dc), 32'd1);
    raw = 1'b1;
    step(7); chk("rstlost.up", 32'(st), 32'd2);
    raw = 1'b0;
    step(5); chk_all("rstlost.k5", 2'd3, 1'b1, 1'b0, 16'd1);
    rst = 1'b1;
    step(1); chk_all("rstlost.rst", 2'd0, 1'b0, 1'b0, 16'd0);
    chk("rstlost.hb", 32'(hb), 32'd0);
    rst = 1'b0;
    step(3); chk_all("rstlost.after", 2'd0, 1'b0, 1'b0, 16'd0);
    raw = 1'b1;
    step(7); raw = 1'b0;
    step(7); chk_all("clr.loss", 2'd0, 1'b0, 1'b1, 16'd1);
    clr = 1'b1;
    step(1); chk("clr.only", 32'(dc), 32'd0);
    clr = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pcie_link_monitor.md
PCIE_LINK_MONITOR -- requirements
Module: pcie_link_monitor

Interface
REQ-001 The block SHALL have parameter HB_HALF_PERIOD, default 62500000, meaning user_clk cycles per heartbeat half-period (minimum 2).
REQ-002 The block SHALL have parameter LNK_FILTER_CYCLES, default 1024, meaning the stable cycles required to qualify a link-up or link-loss transition (minimum 2).
REQ-003 The block SHALL have port user_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 The block SHALL have port user_reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port lnk_up_raw  input  1  unqualified link-up from the PCIe core; may be asynchronous to user_clk.
REQ-006 The block SHALL have port drop_count_clr  input  1  single-cycle request to clear drop_count.
REQ-007 The block SHALL have port user_clk_heartbeat  output  1  free-running square wave for the status LED.
REQ-008 The block SHALL have port user_lnk_up  output  1  filtered link-up for the status LED and downstream logic.
REQ-009 The block SHALL have port lnk_state  output  2  FSM state: 0 DOWN, 1 TRAINING, 2 UP, 3 LOST.
REQ-010 The block SHALL have port lnk_drop_pulse  output  1  one-cycle strobe on a qualified link loss.
REQ-011 The block SHALL have port drop_count  output  16  saturating count of qualified link losses.

Function
REQ-012 lnk_up_raw SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the second flop (lnk_s).
REQ-013 The heartbeat counter SHALL count 0..HB_HALF_PERIOD-1 and wrap; user_clk_heartbeat SHALL toggle on the edge where the counter wraps to 0, independent of link state.
REQ-014 The filter counter SHALL be cleared on every FSM state change and SHALL increment once per cycle in TRAINING and in LOST.
REQ-015 In DOWN: lnk_s=1 SHALL cause a transition to TRAINING; otherwise the FSM SHALL stay in DOWN.
REQ-016 In TRAINING: lnk_s=0 SHALL cause a transition to DOWN; otherwise, when the filter counter is LNK_FILTER_CYCLES-1, the FSM SHALL move to UP.
REQ-017 In UP: lnk_s=0 SHALL cause a transition to LOST.
REQ-018 In LOST: lnk_s=1 SHALL return the FSM to UP (glitch absorbed, no count); otherwise, at filter counter LNK_FILTER_CYCLES-1, the FSM SHALL move to DOWN, drop_count SHALL increment, and lnk_drop_pulse SHALL be driven high.
REQ-019 user_lnk_up SHALL be 1 exactly when the registered state is UP or LOST; lnk_state SHALL equal the registered state.
REQ-020 lnk_drop_pulse SHALL be registered, high for exactly the one cycle following the LOST->DOWN edge.
REQ-021 drop_count SHALL saturate at 0xFFFF; further qualified losses SHALL leave it at 0xFFFF and still pulse lnk_drop_pulse.
REQ-022 drop_count_clr SHALL set drop_count to 0 on the next edge; a clear and an increment on the same edge SHALL yield drop_count=1.
REQ-023 Latency: lnk_up_raw sampled high continuously from edge k SHALL give user_lnk_up=1 after edge k+LNK_FILTER_CYCLES+3; loss SHALL be symmetric (user_lnk_up=0 after edge k+LNK_FILTER_CYCLES+3).

Reset
REQ-024 With user_reset=1 at an edge, the block SHALL set: synchronizer flops 0, state DOWN, filter counter 0, heartbeat counter 0, user_clk_heartbeat 0, user_lnk_up 0, lnk_drop_pulse 0, drop_count 0.
REQ-025 Reset asserted in any state, including mid-filter in TRAINING or LOST, SHALL take effect on that edge with no drop counted and no pulse.
REQ-026 user_reset SHALL take priority over drop_count_clr and all FSM transitions.

Verification (HB_HALF_PERIOD=5, LNK_FILTER_CYCLES=4)
REQ-027 Reset released, lnk_up_raw=0 -> user_clk_heartbeat toggles every 5 cycles (period 10), lnk_state=0, drop_count=0.
REQ-028 lnk_up_raw rises and holds from edge k -> lnk_state=1 after edge k+3, user_lnk_up=1 after edge k+7, lnk_state=2.
REQ-029 In UP, lnk_up_raw low for 2 cycles then high -> lnk_state goes 3 then back to 2; user_lnk_up stays 1; drop_count stays 0; no pulse.
REQ-030 In UP, lnk_up_raw low and held -> user_lnk_up=0 after 7 cycles, lnk_drop_pulse high 1 cycle, drop_count=1; TRAINING with raw dropping at filter count 2 -> back to DOWN, user_lnk_up never 1.
REQ-031 drop_count preloaded to 0xFFFF by 65535 losses (or forced) -> next loss keeps 0xFFFF and pulses; drop_count_clr coincident with a loss -> drop_count=1.
REQ-032 user_reset asserted in LOST at filter count 2 -> next cycle all outputs at reset values, drop_count=0, no pulse.
